// File: rtl/vx_rop_dcr_ctrl_pkg.sv
// ROP render-state types: DCR offset map, field encodings, reset state and the
// register pack/unpack helpers shared by the DCR controller.
package rop_types;

  localparam int unsigned DCR_ADDR_WIDTH = 12;
  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_ROP_STATE_BEGIN = 12'h0C0;

  // Register offsets relative to the ROP state base
  localparam int unsigned ROP_DCR_OFS_W = 5;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_CBUF_ADDR     = 5'd0;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_CBUF_PITCH    = 5'd1;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_CBUF_MASK     = 5'd2;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_ZBUF_ADDR     = 5'd3;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_ZBUF_PITCH    = 5'd4;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_DEPTH_FUNC    = 5'd5;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_DEPTH_MASK    = 5'd6;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_STENCIL_FUNC  = 5'd7;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_STENCIL_ZPASS = 5'd8;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_STENCIL_ZFAIL = 5'd9;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_STENCIL_FAIL  = 5'd10;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_STENCIL_MASK  = 5'd11;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_STENCIL_REF   = 5'd12;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_BLEND_MODE    = 5'd13;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_BLEND_FUNC    = 5'd14;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_BLEND_CONST   = 5'd15;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_LOGIC_OP      = 5'd16;
  localparam logic [ROP_DCR_OFS_W-1:0] ROP_DCR_COMMIT        = 5'd17;
  localparam int unsigned ROP_DCR_NUM = 18;

  // Field widths
  localparam int unsigned ROP_DEPTH_FUNC_W = 3;
  localparam int unsigned ROP_STENCIL_OP_W = 3;
  localparam int unsigned ROP_BLEND_MODE_W = 3;
  localparam int unsigned ROP_BLEND_FUNC_W = 5;
  localparam int unsigned ROP_LOGIC_OP_W   = 4;

  // Compare functions (depth and stencil)
  localparam logic [ROP_DEPTH_FUNC_W-1:0] ROP_DEPTH_FUNC_NEVER    = 3'd0;
  localparam logic [ROP_DEPTH_FUNC_W-1:0] ROP_DEPTH_FUNC_LESS     = 3'd1;
  localparam logic [ROP_DEPTH_FUNC_W-1:0] ROP_DEPTH_FUNC_EQUAL    = 3'd2;
  localparam logic [ROP_DEPTH_FUNC_W-1:0] ROP_DEPTH_FUNC_LEQUAL   = 3'd3;
  localparam logic [ROP_DEPTH_FUNC_W-1:0] ROP_DEPTH_FUNC_GREATER  = 3'd4;
  localparam logic [ROP_DEPTH_FUNC_W-1:0] ROP_DEPTH_FUNC_NOTEQUAL = 3'd5;
  localparam logic [ROP_DEPTH_FUNC_W-1:0] ROP_DEPTH_FUNC_GEQUAL   = 3'd6;
  localparam logic [ROP_DEPTH_FUNC_W-1:0] ROP_DEPTH_FUNC_ALWAYS   = 3'd7;

  // Stencil operations
  localparam logic [ROP_STENCIL_OP_W-1:0] ROP_STENCIL_OP_KEEP      = 3'd0;
  localparam logic [ROP_STENCIL_OP_W-1:0] ROP_STENCIL_OP_ZERO      = 3'd1;
  localparam logic [ROP_STENCIL_OP_W-1:0] ROP_STENCIL_OP_REPLACE   = 3'd2;
  localparam logic [ROP_STENCIL_OP_W-1:0] ROP_STENCIL_OP_INCR      = 3'd3;
  localparam logic [ROP_STENCIL_OP_W-1:0] ROP_STENCIL_OP_DECR      = 3'd4;
  localparam logic [ROP_STENCIL_OP_W-1:0] ROP_STENCIL_OP_INVERT    = 3'd5;
  localparam logic [ROP_STENCIL_OP_W-1:0] ROP_STENCIL_OP_INCR_WRAP = 3'd6;
  localparam logic [ROP_STENCIL_OP_W-1:0] ROP_STENCIL_OP_DECR_WRAP = 3'd7;

  // Blend equations
  localparam logic [ROP_BLEND_MODE_W-1:0] ROP_BLEND_MODE_ADD     = 3'd0;
  localparam logic [ROP_BLEND_MODE_W-1:0] ROP_BLEND_MODE_SUB     = 3'd1;
  localparam logic [ROP_BLEND_MODE_W-1:0] ROP_BLEND_MODE_REV_SUB = 3'd2;
  localparam logic [ROP_BLEND_MODE_W-1:0] ROP_BLEND_MODE_MIN     = 3'd3;
  localparam logic [ROP_BLEND_MODE_W-1:0] ROP_BLEND_MODE_MAX     = 3'd4;
  localparam logic [ROP_BLEND_MODE_W-1:0] ROP_BLEND_MODE_LOGICOP = 3'd5;

  // Blend factors
  localparam logic [ROP_BLEND_FUNC_W-1:0] ROP_BLEND_FUNC_ZERO          = 5'd0;
  localparam logic [ROP_BLEND_FUNC_W-1:0] ROP_BLEND_FUNC_ONE           = 5'd1;
  localparam logic [ROP_BLEND_FUNC_W-1:0] ROP_BLEND_FUNC_SRC_RGB       = 5'd2;
  localparam logic [ROP_BLEND_FUNC_W-1:0] ROP_BLEND_FUNC_ONE_MINUS_SRC = 5'd3;
  localparam logic [ROP_BLEND_FUNC_W-1:0] ROP_BLEND_FUNC_SRC_A         = 5'd4;
  localparam logic [ROP_BLEND_FUNC_W-1:0] ROP_BLEND_FUNC_ONE_MINUS_SA  = 5'd5;

  // Logic operations
  localparam logic [ROP_LOGIC_OP_W-1:0] ROP_LOGIC_OP_CLEAR = 4'd0;
  localparam logic [ROP_LOGIC_OP_W-1:0] ROP_LOGIC_OP_AND   = 4'd1;
  localparam logic [ROP_LOGIC_OP_W-1:0] ROP_LOGIC_OP_COPY  = 4'd3;
  localparam logic [ROP_LOGIC_OP_W-1:0] ROP_LOGIC_OP_XOR   = 4'd6;
  localparam logic [ROP_LOGIC_OP_W-1:0] ROP_LOGIC_OP_OR    = 4'd7;

  typedef struct packed {
    logic [31:0]                 cbuf_addr;
    logic [31:0]                 cbuf_pitch;
    logic [31:0]                 cbuf_mask;
    logic [31:0]                 zbuf_addr;
    logic [31:0]                 zbuf_pitch;
    logic [ROP_DEPTH_FUNC_W-1:0] depth_func;
    logic                        depth_mask;
    logic [ROP_DEPTH_FUNC_W-1:0] stencil_front_func;
    logic [ROP_DEPTH_FUNC_W-1:0] stencil_back_func;
    logic [ROP_STENCIL_OP_W-1:0] stencil_front_zpass;
    logic [ROP_STENCIL_OP_W-1:0] stencil_back_zpass;
    logic [ROP_STENCIL_OP_W-1:0] stencil_front_zfail;
    logic [ROP_STENCIL_OP_W-1:0] stencil_back_zfail;
    logic [ROP_STENCIL_OP_W-1:0] stencil_front_fail;
    logic [ROP_STENCIL_OP_W-1:0] stencil_back_fail;
    logic [7:0]                  stencil_front_mask;
    logic [7:0]                  stencil_back_mask;
    logic [7:0]                  stencil_front_ref;
    logic [7:0]                  stencil_back_ref;
    logic [ROP_BLEND_MODE_W-1:0] blend_mode_rgb;
    logic [ROP_BLEND_MODE_W-1:0] blend_mode_a;
    logic [ROP_BLEND_FUNC_W-1:0] blend_src_rgb;
    logic [ROP_BLEND_FUNC_W-1:0] blend_src_a;
    logic [ROP_BLEND_FUNC_W-1:0] blend_dst_rgb;
    logic [ROP_BLEND_FUNC_W-1:0] blend_dst_a;
    logic [31:0]                 blend_const;
    logic [ROP_LOGIC_OP_W-1:0]   logic_op;
  } rop_dcrs_t;

  localparam rop_dcrs_t ROP_DCRS_RESET = '{
    cbuf_addr:           32'h0,
    cbuf_pitch:          32'h0,
    cbuf_mask:           32'hFFFF_FFFF,
    zbuf_addr:           32'h0,
    zbuf_pitch:          32'h0,
    depth_func:          ROP_DEPTH_FUNC_ALWAYS,
    depth_mask:          1'b1,
    stencil_front_func:  ROP_DEPTH_FUNC_ALWAYS,
    stencil_back_func:   ROP_DEPTH_FUNC_ALWAYS,
    stencil_front_zpass: ROP_STENCIL_OP_KEEP,
    stencil_back_zpass:  ROP_STENCIL_OP_KEEP,
    stencil_front_zfail: ROP_STENCIL_OP_KEEP,
    stencil_back_zfail:  ROP_STENCIL_OP_KEEP,
    stencil_front_fail:  ROP_STENCIL_OP_KEEP,
    stencil_back_fail:   ROP_STENCIL_OP_KEEP,
    stencil_front_mask:  8'hFF,
    stencil_back_mask:   8'hFF,
    stencil_front_ref:   8'h00,
    stencil_back_ref:    8'h00,
    blend_mode_rgb:      ROP_BLEND_MODE_ADD,
    blend_mode_a:        ROP_BLEND_MODE_ADD,
    blend_src_rgb:       ROP_BLEND_FUNC_ONE,
    blend_src_a:         ROP_BLEND_FUNC_ONE,
    blend_dst_rgb:       ROP_BLEND_FUNC_ZERO,
    blend_dst_a:         ROP_BLEND_FUNC_ZERO,
    blend_const:         32'h0,
    logic_op:            ROP_LOGIC_OP_COPY
  };

  // Apply a register write to a state copy; unpacked bits are dropped.
  function automatic rop_dcrs_t rop_dcr_write(input rop_dcrs_t cur,
                                              input logic [ROP_DCR_OFS_W-1:0] ofs,
                                              input logic [31:0] data);
    rop_dcrs_t nxt;
    nxt = cur;
    case (ofs)
      ROP_DCR_CBUF_ADDR:  nxt.cbuf_addr  = data;
      ROP_DCR_CBUF_PITCH: nxt.cbuf_pitch = data;
      ROP_DCR_CBUF_MASK:  nxt.cbuf_mask  = data;
      ROP_DCR_ZBUF_ADDR:  nxt.zbuf_addr  = data;
      ROP_DCR_ZBUF_PITCH: nxt.zbuf_pitch = data;
      ROP_DCR_DEPTH_FUNC: nxt.depth_func = data[2:0];
      ROP_DCR_DEPTH_MASK: nxt.depth_mask = data[0];
      ROP_DCR_STENCIL_FUNC: begin
        nxt.stencil_front_func = data[2:0];
        nxt.stencil_back_func  = data[18:16];
      end
      ROP_DCR_STENCIL_ZPASS: begin
        nxt.stencil_front_zpass = data[2:0];
        nxt.stencil_back_zpass  = data[18:16];
      end
      ROP_DCR_STENCIL_ZFAIL: begin
        nxt.stencil_front_zfail = data[2:0];
        nxt.stencil_back_zfail  = data[18:16];
      end
      ROP_DCR_STENCIL_FAIL: begin
        nxt.stencil_front_fail = data[2:0];
        nxt.stencil_back_fail  = data[18:16];
      end
      ROP_DCR_STENCIL_MASK: begin
        nxt.stencil_front_mask = data[7:0];
        nxt.stencil_back_mask  = data[23:16];
      end
      ROP_DCR_STENCIL_REF: begin
        nxt.stencil_front_ref = data[7:0];
        nxt.stencil_back_ref  = data[23:16];
      end
      ROP_DCR_BLEND_MODE: begin
        nxt.blend_mode_rgb = data[2:0];
        nxt.blend_mode_a   = data[18:16];
      end
      ROP_DCR_BLEND_FUNC: begin
        nxt.blend_src_rgb = data[4:0];
        nxt.blend_src_a   = data[12:8];
        nxt.blend_dst_rgb = data[20:16];
        nxt.blend_dst_a   = data[28:24];
      end
      ROP_DCR_BLEND_CONST: nxt.blend_const = data;
      ROP_DCR_LOGIC_OP:    nxt.logic_op    = data[3:0];
      default: ;
    endcase
    return nxt;
  endfunction

  // Pack a register for readback; COMMIT and unmapped offsets read 0 here.
  function automatic logic [31:0] rop_dcr_read(input rop_dcrs_t cur,
                                               input logic [ROP_DCR_OFS_W-1:0] ofs);
    logic [31:0] rd;
    rd = '0;
    case (ofs)
      ROP_DCR_CBUF_ADDR:     rd = cur.cbuf_addr;
      ROP_DCR_CBUF_PITCH:    rd = cur.cbuf_pitch;
      ROP_DCR_CBUF_MASK:     rd = cur.cbuf_mask;
      ROP_DCR_ZBUF_ADDR:     rd = cur.zbuf_addr;
      ROP_DCR_ZBUF_PITCH:    rd = cur.zbuf_pitch;
      ROP_DCR_DEPTH_FUNC:    rd = {29'b0, cur.depth_func};
      ROP_DCR_DEPTH_MASK:    rd = {31'b0, cur.depth_mask};
      ROP_DCR_STENCIL_FUNC:  rd = {13'b0, cur.stencil_back_func, 13'b0, cur.stencil_front_func};
      ROP_DCR_STENCIL_ZPASS: rd = {13'b0, cur.stencil_back_zpass, 13'b0, cur.stencil_front_zpass};
      ROP_DCR_STENCIL_ZFAIL: rd = {13'b0, cur.stencil_back_zfail, 13'b0, cur.stencil_front_zfail};
      ROP_DCR_STENCIL_FAIL:  rd = {13'b0, cur.stencil_back_fail, 13'b0, cur.stencil_front_fail};
      ROP_DCR_STENCIL_MASK:  rd = {8'b0, cur.stencil_back_mask, 8'b0, cur.stencil_front_mask};
      ROP_DCR_STENCIL_REF:   rd = {8'b0, cur.stencil_back_ref, 8'b0, cur.stencil_front_ref};
      ROP_DCR_BLEND_MODE:    rd = {13'b0, cur.blend_mode_a, 13'b0, cur.blend_mode_rgb};
      ROP_DCR_BLEND_FUNC:    rd = {3'b0, cur.blend_dst_a, 3'b0, cur.blend_dst_rgb,
                                   3'b0, cur.blend_src_a, 3'b0, cur.blend_src_rgb};
      ROP_DCR_BLEND_CONST:   rd = cur.blend_const;
      ROP_DCR_LOGIC_OP:      rd = {28'b0, cur.logic_op};
      default:               rd = '0;
    endcase
    return rd;
  endfunction

endpackage

// File: rtl/vx_rop_dcr_ctrl.sv
// ROP DCR controller: writes land in a shadow copy of the render state; a COMMIT
// write waits for the ROP pipeline to drain, then copies shadow to the active state.
module vx_rop_dcr_ctrl
  import rop_types::*;
#(
  parameter logic [DCR_ADDR_WIDTH-1:0] DCR_BASE = DCR_ROP_STATE_BEGIN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dcr_wr_valid,
  output logic                      dcr_wr_ready,
  input  logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  input  logic [31:0]               dcr_wr_data,
  input  logic                      dcr_rd_valid,
  input  logic [DCR_ADDR_WIDTH-1:0] dcr_rd_addr,
  output logic                      dcr_rd_rsp_valid,
  output logic [31:0]               dcr_rd_rsp_data,
  input  logic                      rop_busy,
  output rop_dcrs_t                 dcrs,
  output logic                      commit_done,
  output logic                      addr_err
);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  localparam logic [DCR_ADDR_WIDTH-1:0] NumOfs = DCR_ADDR_WIDTH'(ROP_DCR_NUM);

  state_e      state_q, state_d;
  rop_dcrs_t   shadow_q, shadow_d;
  rop_dcrs_t   dcrs_q, dcrs_d;
  logic        commit_done_q, commit_done_d;
  logic        addr_err_q, addr_err_d;
  logic        rd_rsp_valid_q, rd_rsp_valid_d;
  logic [31:0] rd_rsp_data_q, rd_rsp_data_d;

  logic [DCR_ADDR_WIDTH-1:0] wr_ofs_full, rd_ofs_full;
  logic [ROP_DCR_OFS_W-1:0]  wr_ofs, rd_ofs;
  logic                      wr_mapped, rd_mapped;

  // Addresses below the base wrap to a huge offset, so both bounds are checked.
  assign wr_ofs_full = dcr_wr_addr - DCR_BASE;
  assign rd_ofs_full = dcr_rd_addr - DCR_BASE;
  assign wr_mapped   = (dcr_wr_addr >= DCR_BASE) && (wr_ofs_full < NumOfs);
  assign rd_mapped   = (dcr_rd_addr >= DCR_BASE) && (rd_ofs_full < NumOfs);
  assign wr_ofs      = wr_ofs_full[ROP_DCR_OFS_W-1:0];
  assign rd_ofs      = rd_ofs_full[ROP_DCR_OFS_W-1:0];

  // Writes are only accepted while no commit is pending.
  assign dcr_wr_ready = (state_q == StIdle);

  // Next-state: commit FSM, shadow writes, readback and error flag
  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    dcrs_d         = dcrs_q;
    commit_done_d  = 1'b0;
    addr_err_d     = addr_err_q;
    rd_rsp_valid_d = dcr_rd_valid;
    rd_rsp_data_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (dcr_wr_valid) begin
          if (!wr_mapped) begin
            addr_err_d = 1'b1;
          end else if (wr_ofs == ROP_DCR_COMMIT) begin
            state_d = StDrain;
          end else begin
            shadow_d = rop_dcr_write(shadow_q, wr_ofs, dcr_wr_data);
          end
        end
      end
      StDrain: begin
        if (!rop_busy) begin
          state_d       = StIdle;
          dcrs_d        = shadow_q;
          commit_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reads see shadow_q, i.e. the value before any same-cycle write.
    if (dcr_rd_valid) begin
      if (!rd_mapped) begin
        addr_err_d = 1'b1;
      end else if (rd_ofs == ROP_DCR_COMMIT) begin
        rd_rsp_data_d = {31'b0, state_q == StDrain};
      end else begin
        rd_rsp_data_d = rop_dcr_read(shadow_q, rd_ofs);
      end
    end
  end

  // State registers; reset drops any pending commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      shadow_q       <= ROP_DCRS_RESET;
      dcrs_q         <= ROP_DCRS_RESET;
      commit_done_q  <= 1'b0;
      addr_err_q     <= 1'b0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      dcrs_q         <= dcrs_d;
      commit_done_q  <= commit_done_d;
      addr_err_q     <= addr_err_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      rd_rsp_data_q  <= rd_rsp_data_d;
    end
  end

  assign dcrs             = dcrs_q;
  assign commit_done      = commit_done_q;
  assign addr_err         = addr_err_q;
  assign dcr_rd_rsp_valid = rd_rsp_valid_q;
  assign dcr_rd_rsp_data  = rd_rsp_data_q;

endmodule

// File: tb/tb_vx_rop_dcr_ctrl.sv
// Bench for vx_rop_dcr_ctrl: readback responses go through a scoreboard queue,
// state/strobe outputs are checked directly after each edge.
module tb_vx_rop_dcr_ctrl;
  import rop_types::*;

  localparam logic [11:0] BASE = 12'h0C0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dcr_wr_valid = 1'b0;
  logic        dcr_wr_ready;
  logic [11:0] dcr_wr_addr = '0;
  logic [31:0] dcr_wr_data = '0;
  logic        dcr_rd_valid = 1'b0;
  logic [11:0] dcr_rd_addr = '0;
  logic        dcr_rd_rsp_valid;
  logic [31:0] dcr_rd_rsp_data;
  logic        rop_busy = 1'b0;
  rop_dcrs_t   dcrs;
  logic        commit_done;
  logic        addr_err;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  rop_dcrs_t   exp_reset;

  vx_rop_dcr_ctrl #(.DCR_BASE(BASE)) dut (
    .clk              (clk),
    .reset            (reset),
    .dcr_wr_valid     (dcr_wr_valid),
    .dcr_wr_ready     (dcr_wr_ready),
    .dcr_wr_addr      (dcr_wr_addr),
    .dcr_wr_data      (dcr_wr_data),
    .dcr_rd_valid     (dcr_rd_valid),
    .dcr_rd_addr      (dcr_rd_addr),
    .dcr_rd_rsp_valid (dcr_rd_rsp_valid),
    .dcr_rd_rsp_data  (dcr_rd_rsp_data),
    .rop_busy         (rop_busy),
    .dcrs             (dcrs),
    .commit_done      (commit_done),
    .addr_err         (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Scoreboard monitor: every response must match the oldest outstanding read
  always @(negedge clk) begin
    if (reset && dcr_rd_rsp_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_rsp: unexpected response data=%h, none outstanding", dcr_rd_rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dcr_rd_rsp_data !== mon_exp) begin
          bad++;
          $display("FAIL rd_rsp: got %h want %h", dcr_rd_rsp_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_dcrs(input string name, input rop_dcrs_t exp);
    total++;
    if (dcrs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, dcrs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a write until accepted (bounded); returns 1 ns after the accept edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = a;
    dcr_wr_data  = d;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = dcr_wr_ready;
      @(posedge clk);
      #1;
      n++;
    end
    dcr_wr_valid = 1'b0;
    check("wr_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    dcr_rd_valid = 1'b1;
    dcr_rd_addr  = a;
    exp_q.push_back(e);
    tick();
    dcr_rd_valid = 1'b0;
  endtask

  initial begin
    exp_reset = '0;
    exp_reset.cbuf_mask          = 32'hFFFF_FFFF;
    exp_reset.depth_func         = 3'd7;
    exp_reset.depth_mask         = 1'b1;
    exp_reset.stencil_front_func = 3'd7;
    exp_reset.stencil_back_func  = 3'd7;
    exp_reset.stencil_front_mask = 8'hFF;
    exp_reset.stencil_back_mask  = 8'hFF;
    exp_reset.blend_src_rgb      = 5'd1;
    exp_reset.blend_src_a        = 5'd1;
    exp_reset.logic_op           = 4'd3;

    // Reset state
    repeat (3) tick();
    check("rst_rsp_valid", {31'b0, dcr_rd_rsp_valid}, 32'd0);
    check("rst_commit_done", {31'b0, commit_done}, 32'd0);
    check("rst_addr_err", {31'b0, addr_err}, 32'd0);
    check("rst_wr_ready", {31'b0, dcr_wr_ready}, 32'd1);
    check_dcrs("rst_dcrs", exp_reset);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Reset readback of packed registers
    rd(BASE + 12'd2,  32'hFFFF_FFFF);
    rd(BASE + 12'd5,  32'h0000_0007);
    rd(BASE + 12'd6,  32'h0000_0001);
    rd(BASE + 12'd7,  32'h0007_0007);
    rd(BASE + 12'd11, 32'h00FF_00FF);
    rd(BASE + 12'd14, 32'h0000_0101);
    rd(BASE + 12'd16, 32'h0000_0003);
    rd(BASE + 12'd17, 32'h0000_0000);
    check_dcrs("post_rst_dcrs", exp_reset);

    // Shadow write, then commit with the pipeline idle
    wr(BASE + 12'd0, 32'h8000_0000);
    check("shadow_no_active", dcrs.cbuf_addr, 32'h0);
    rd(BASE + 12'd0, 32'h8000_0000);
    wr(BASE + 12'd17, 32'hFFFF_FFFF);
    check("commit_accept_active", dcrs.cbuf_addr, 32'h0);
    check("commit_accept_ready", {31'b0, dcr_wr_ready}, 32'd0);
    check("commit_accept_done", {31'b0, commit_done}, 32'd0);
    tick();
    check("commit_active", dcrs.cbuf_addr, 32'h8000_0000);
    check("commit_done_pulse", {31'b0, commit_done}, 32'd1);
    check("commit_ready_back", {31'b0, dcr_wr_ready}, 32'd1);
    tick();
    check("commit_done_once", {31'b0, commit_done}, 32'd0);

    // Commit held off by a busy pipeline; a write presented meanwhile stalls
    wr(BASE + 12'd2, 32'h0000_FFFF);
    rop_busy = 1'b1;
    wr(BASE + 12'd17, 32'h0);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = BASE + 12'd1;
    dcr_wr_data  = 32'h0000_1234;
    for (int i = 0; i < 5; i++) begin
      check("drain_ready", {31'b0, dcr_wr_ready}, 32'd0);
      check("drain_active", dcrs.cbuf_mask, 32'hFFFF_FFFF);
      check("drain_done", {31'b0, commit_done}, 32'd0);
      dcr_rd_valid = (i < 2);
      dcr_rd_addr  = (i == 0) ? BASE + 12'd17 : BASE + 12'd1;
      if (i == 0) exp_q.push_back(32'h1);
      if (i == 1) exp_q.push_back(32'h0);
      tick();
    end
    dcr_rd_valid = 1'b0;
    rop_busy = 1'b0;
    check("busy_fall_ready", {31'b0, dcr_wr_ready}, 32'd0);
    check("busy_fall_active", dcrs.cbuf_mask, 32'hFFFF_FFFF);
    tick();
    check("drain_commit_active", dcrs.cbuf_mask, 32'h0000_FFFF);
    check("drain_commit_done", {31'b0, commit_done}, 32'd1);
    check("drain_commit_ready", {31'b0, dcr_wr_ready}, 32'd1);
    tick();
    dcr_wr_valid = 1'b0;
    check("held_wr_not_active", dcrs.cbuf_pitch, 32'h0);
    rd(BASE + 12'd1, 32'h0000_1234);

    // Field packing with ignored bits, and stencil ref through a commit
    wr(BASE + 12'd12, 32'h0042_0017);
    rd(BASE + 12'd12, 32'h0042_0017);
    wr(BASE + 12'd7, 32'hFFFF_FFFA);
    rd(BASE + 12'd7, 32'h0007_0002);
    wr(BASE + 12'd14, 32'hFFFF_FFFF);
    rd(BASE + 12'd14, 32'h1F1F_1F1F);
    wr(BASE + 12'd13, 32'h0005_0003);
    rd(BASE + 12'd13, 32'h0005_0003);
    wr(BASE + 12'd17, 32'h0);
    tick();
    check("stencil_front_ref", {24'b0, dcrs.stencil_front_ref}, 32'h17);
    check("stencil_back_ref", {24'b0, dcrs.stencil_back_ref}, 32'h42);
    check("stencil_front_func", {29'b0, dcrs.stencil_front_func}, 32'd2);
    check("blend_dst_a", {27'b0, dcrs.blend_dst_a}, 32'h1F);

    // Same-cycle read and write to one offset returns the old value
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = BASE + 12'd15;
    dcr_wr_data  = 32'hDEAD_BEEF;
    rd(BASE + 12'd15, 32'h0);
    dcr_wr_valid = 1'b0;
    rd(BASE + 12'd15, 32'hDEAD_BEEF);
    check("no_err_yet", {31'b0, addr_err}, 32'd0);

    // Unmapped accesses: accepted, discarded, sticky error
    wr(BASE + 12'd40, 32'h0000_0055);
    check("unmapped_wr_err", {31'b0, addr_err}, 32'd1);
    rd(BASE + 12'd0, 32'h8000_0000);
    rd(BASE + 12'd40, 32'h0);
    rd(BASE + 12'd18, 32'h0);
    rd(BASE - 12'd1, 32'h0);
    repeat (3) tick();
    check("err_sticky", {31'b0, addr_err}, 32'd1);
    check("unmapped_no_commit", {31'b0, commit_done}, 32'd0);

    // Reset during DRAIN abandons the commit
    wr(BASE + 12'd0, 32'h0000_1111);
    rop_busy = 1'b1;
    wr(BASE + 12'd17, 32'h0);
    check("pre_rst_drain", {31'b0, dcr_wr_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_drain_ready", {31'b0, dcr_wr_ready}, 32'd1);
    check("rst_drain_done", {31'b0, commit_done}, 32'd0);
    check("rst_drain_err", {31'b0, addr_err}, 32'd0);
    check("rst_drain_rsp", {31'b0, dcr_rd_rsp_valid}, 32'd0);
    check_dcrs("rst_drain_dcrs", exp_reset);
    @(negedge clk);
    reset = 1'b1;
    rop_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_done_after_rst", {31'b0, commit_done}, 32'd0);
    end
    check_dcrs("rst_drain_dcrs_hold", exp_reset);
    rd(BASE + 12'd0, 32'h0);

    repeat (3) tick();
    check("rd_outstanding", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_rop_dcr_ctrl.md
VX_ROP_DCR_CTRL -- requirements
Module: VX_rop_dcr_ctrl

Interface
REQ-001 SHALL have parameter DCR_BASE, default `DCR_ROP_STATE_BEGIN, giving the DCR address of register offset 0.
REQ-002 SHALL have port clk, input, 1, the single clock; the block has one clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port dcr_wr_valid, input, 1, DCR write request.
REQ-005 SHALL have port dcr_wr_ready, output, 1, write accepted when valid && ready at a rising edge.
REQ-006 SHALL have port dcr_wr_addr, input, `VX_DCR_ADDR_WIDTH, DCR write address.
REQ-007 SHALL have port dcr_wr_data, input, 32, DCR write data.
REQ-008 SHALL have port dcr_rd_valid, input, 1, readback request; there is no ready and reads are always accepted.
REQ-009 SHALL have port dcr_rd_addr, input, `VX_DCR_ADDR_WIDTH, readback address.
REQ-010 SHALL have port dcr_rd_rsp_valid, output, 1, readback response strobe.
REQ-011 SHALL have port dcr_rd_rsp_data, output, 32, readback data.
REQ-012 SHALL have port rop_busy, input, 1, ROP pipeline holds fragments that use the active state.
REQ-013 SHALL have port dcrs, output, rop_dcrs_t, the active state consumed by the ROP unit.
REQ-014 SHALL have port commit_done, output, 1, one-cycle pulse when the shadow state is copied to the active state.
REQ-015 SHALL have port addr_err, output, 1, sticky flag set by any access to an unmapped address.

Function
REQ-016 SHALL decode offset = addr - DCR_BASE into this map:
- 0 CBUF_ADDR
- 1 CBUF_PITCH
- 2 CBUF_MASK
- 3 ZBUF_ADDR
- 4 ZBUF_PITCH
- 5 DEPTH_FUNC
- 6 DEPTH_MASK
- 7 STENCIL_FUNC
- 8 STENCIL_ZPASS
- 9 STENCIL_ZFAIL
- 10 STENCIL_FAIL
- 11 STENCIL_MASK
- 12 STENCIL_REF
- 13 BLEND_MODE
- 14 BLEND_FUNC
- 15 BLEND_CONST
- 16 LOGIC_OP
- 17 COMMIT
Any other offset, including addresses below DCR_BASE, is unmapped.
REQ-017 SHALL pack stencil registers 7-12 with the front field at data[N-1:0] and the back field at data[16+N-1:16], where N is the field width; all other bits are ignored on write and read as 0.
REQ-018 SHALL pack BLEND_MODE as rgb at [15:0] and a at [31:16], LSB-aligned within each half.
REQ-019 SHALL pack BLEND_FUNC as src_rgb [7:0], src_a [15:8], dst_rgb [23:16], dst_a [31:24].
REQ-020 SHALL pack all remaining fields LSB-aligned.
REQ-021 SHALL update the shadow rop_dcrs_t at the edge where a write to offsets 0-16 is accepted; dcrs SHALL be unaffected by that write.
REQ-022 SHALL implement the FSM IDLE->DRAIN on an accepted COMMIT write (data ignored), and DRAIN->IDLE at the first edge where rop_busy==0; at that edge dcrs <= shadow.
REQ-023 SHALL assert commit_done for exactly the one cycle following the DRAIN->IDLE edge.
REQ-024 SHALL drive dcr_wr_ready = (state==IDLE), so the minimum commit latency is 1 cycle from the accept edge to the dcrs update.
REQ-025 SHALL accept writes to unmapped addresses in IDLE, discard them, and set addr_err.
REQ-026 SHALL return shadow values on readback, registered, with dcr_rd_rsp_valid and dcr_rd_rsp_data valid the cycle after dcr_rd_valid.
REQ-027 SHALL read COMMIT as {31'b0, state==DRAIN} and unmapped offsets as 0 (also setting addr_err).
REQ-028 SHALL, when a read and an accepted write target the same offset in the same cycle, return the pre-write value.
REQ-029 SHALL service reads in both IDLE and DRAIN.
REQ-030 SHALL clear addr_err only by reset.

Reset
REQ-031 SHALL, on reset assertion, immediately force state=IDLE, commit_done=0, dcr_rd_rsp_valid=0, dcr_rd_rsp_data=0, and addr_err=0.
REQ-032 SHALL reset both shadow and active state to ROP_DCRS_RESET: cbuf_mask=0xFFFFFFFF, depth_func=ALWAYS, depth_mask=1, stencil funcs=ALWAYS, stencil ops=KEEP, stencil masks=0xFF, stencil refs=0, blend modes=ADD, src funcs=ONE, dst funcs=ZERO, blend_const=0, logic_op=COPY, addresses and pitches=0.
REQ-033 SHALL abandon any pending commit when reset is asserted during DRAIN, with no commit_done pulse after release.

Structure
REQ-034 SHALL place register offsets (ROP_DCR_*), ROP_DCR_NUM=18, and the ROP_DCRS_RESET constant in package rop_types alongside rop_dcrs_t.
REQ-035 SHALL be a single module with no sub-module.

Verification
REQ-036 SHALL cover: after reset, read offset 2 -> rsp next cycle = 0xFFFFFFFF, and dcrs equals ROP_DCRS_RESET.
REQ-037 SHALL cover: write CBUF_ADDR=0x8000_0000, then COMMIT with rop_busy=0 -> dcrs.cbuf_addr unchanged until 1 edge after the commit accept, then commit_done pulses for 1 cycle.
REQ-038 SHALL cover: COMMIT with rop_busy=1 for 5 cycles -> dcr_wr_ready=0 for those cycles, a held write stalls, and dcrs updates on the edge after busy falls.
REQ-039 SHALL cover: write STENCIL_REF=0x0042_0017 -> readback 0x0042_0017, front_ref=0x17, back_ref=0x42 after commit.
REQ-040 SHALL cover: write to DCR_BASE+40 -> accepted, no state change, addr_err=1 until reset.
REQ-041 SHALL cover: assert reset during DRAIN -> IDLE, dcrs=ROP_DCRS_RESET, and no commit_done.
